sift_stage_sequencer: RTL and testbench

SIFT_STAGE_SEQUENCER -- requirements
Module: sift_stage_sequencer

---
 rtl/sift_stage_sequencer_pkg.sv | 32 +++
 rtl/sift_stage_timer.sv | 35 +++
 rtl/sift_stage_sequencer.sv | 164 ++++++++++++++++
 tb/tb_sift_stage_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sift_stage_sequencer_pkg.sv
// Shared types for the SIFT stage sequencer:
// state encodings, mux select codes and report helpers.
package sift_stage_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GAUSS  = 3'd1,
    ST_DETECT = 3'd2,
    ST_MATCH  = 3'd3,
    ST_REPORT = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  localparam logic [1:0] SEL_NONE   = 2'd0;
  localparam logic [1:0] SEL_GAUSS  = 2'd1;
  localparam logic [1:0] SEL_DETECT = 2'd2;
  localparam logic [1:0] SEL_MATCH  = 2'd3;

  localparam int RPT_WORDS = 4;

  typedef struct packed {
    logic [10:0] kpt1;
    logic [10:0] kpt2;
    logic [15:0] det_cyc;
    logic [15:0] mat_cyc;
  } run_stats_t;

  function automatic logic [15:0] sat16(input logic [31:0] v);
    return (v > 32'h0000_ffff) ? 16'hffff : v[15:0];
  endfunction

endpackage

// File: rtl/sift_stage_timer.sv
// Per-stage cycle counter: loads 1 on stage entry,
// saturates at all-ones and flags the timeout count.
module sift_stage_timer #(
  parameter int TIMEOUT_CYC = 2000000,
  parameter int CNT_W       = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  output logic [CNT_W-1:0] cnt,
  output logic             first,
  output logic             hit
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT_CYC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_ONE;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign first = (cnt == CNT_ONE);
  assign hit   = (cnt == CNT_TMO);

endmodule

// File: rtl/sift_stage_sequencer.sv
// Sequences gauss -> detect -> match stages for one SIFT run,
// with per-stage timeout and a 4-word status report.
module sift_stage_sequencer
  import sift_stage_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2000000,
  parameter int CNT_W       = 22
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        gauss_start,
  output logic        detect_start,
  output logic        match_start,
  input  logic        gauss_done,
  input  logic        detect_done,
  input  logic        match_done,
  input  logic [10:0] kpt1_cnt,
  input  logic [10:0] kpt2_cnt,
  output logic [1:0]  sel,
  output logic        busy,
  output logic        err,
  output logic        out_valid,
  output logic [15:0] out_data
);

  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(RPT_WORDS);

  state_t           state_q;
  state_t           state_d;
  logic             iv_q;
  logic             iv_seen;
  logic             iv_edge;
  run_stats_t       stats_q;
  logic [CNT_W-1:0] cnt;
  logic             first;
  logic             hit;
  logic             load;
  logic             run_on;
  logic             g_fire;
  logic             d_fire;
  logic             m_fire;
  logic             kpt_zero;

  // iv_seen blocks a held-high in_valid from looking like an edge after reset
  assign iv_edge  = in_valid & ~iv_q & iv_seen;
  assign g_fire   = (state_q == ST_GAUSS) & gauss_done & ~first;
  assign d_fire   = (state_q == ST_DETECT) & detect_done & ~first;
  assign m_fire   = (state_q == ST_MATCH) & match_done & ~first;
  assign kpt_zero = (kpt1_cnt == 11'd0) & (kpt2_cnt == 11'd0);

  assign run_on = (state_q == ST_GAUSS) | (state_q == ST_DETECT) |
                  (state_q == ST_MATCH) | (state_q == ST_REPORT);

  assign load = (state_d != state_q) &
                ((state_d == ST_GAUSS) | (state_d == ST_DETECT) |
                 (state_d == ST_MATCH) | (state_d == ST_REPORT));

  sift_stage_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (run_on),
    .load (load),
    .cnt  (cnt),
    .first(first),
    .hit  (hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      iv_q    <= 1'b0;
      iv_seen <= 1'b0;
      stats_q <= '0;
    end else begin
      state_q <= state_d;
      iv_q    <= in_valid;
      iv_seen <= 1'b1;
      if ((state_q == ST_IDLE) && (state_d == ST_GAUSS)) begin
        stats_q <= '0;
      end
      if (d_fire) begin
        stats_q.kpt1    <= kpt1_cnt;
        stats_q.kpt2    <= kpt2_cnt;
        stats_q.det_cyc <= sat16(32'(cnt));
      end
      if (m_fire) begin
        stats_q.mat_cyc <= sat16(32'(cnt));
      end
    end
  end

  // done beats timeout when both land on the same cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (iv_edge) state_d = ST_GAUSS;
      end
      ST_GAUSS: begin
        if (g_fire)   state_d = ST_DETECT;
        else if (hit) state_d = ST_ERR;
      end
      ST_DETECT: begin
        if (d_fire)   state_d = kpt_zero ? ST_REPORT : ST_MATCH;
        else if (hit) state_d = ST_ERR;
      end
      ST_MATCH: begin
        if (m_fire)   state_d = ST_REPORT;
        else if (hit) state_d = ST_ERR;
      end
      ST_REPORT: begin
        if (cnt == RPT_LAST) state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    gauss_start  = 1'b0;
    detect_start = 1'b0;
    match_start  = 1'b0;
    sel          = SEL_NONE;
    busy         = run_on;
    err          = (state_q == ST_ERR);
    out_valid    = 1'b0;
    out_data     = 16'h0000;
    unique case (1'b1)
      (state_q == ST_GAUSS): begin
        sel         = SEL_GAUSS;
        gauss_start = first;
      end
      (state_q == ST_DETECT): begin
        sel          = SEL_DETECT;
        detect_start = first;
      end
      (state_q == ST_MATCH): begin
        sel         = SEL_MATCH;
        match_start = first;
      end
      (state_q == ST_REPORT): begin
        out_valid = 1'b1;
        unique case (cnt[1:0])
          2'd1:    out_data = {5'b0, stats_q.kpt1};
          2'd2:    out_data = {5'b0, stats_q.kpt2};
          2'd3:    out_data = stats_q.det_cyc;
          default: out_data = stats_q.mat_cyc;
        endcase
      end
      default: begin
        sel = SEL_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_sift_stage_sequencer.sv
// Scoreboard bench for sift_stage_sequencer: report words are
// queued when done pulses are driven and popped on out_valid.
module tb_sift_stage_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        gauss_done = 1'b0;
  logic        detect_done = 1'b0;
  logic        match_done = 1'b0;
  logic [10:0] kpt1_cnt = 11'd0;
  logic [10:0] kpt2_cnt = 11'd0;

  logic        gauss_start, detect_start, match_start;
  logic [1:0]  sel;
  logic        busy, err, out_valid;
  logic [15:0] out_data;

  logic        t_gauss_start, t_detect_start, t_match_start;
  logic [1:0]  t_sel;
  logic        t_busy, t_err, t_out_valid;
  logic [15:0] t_out_data;

  int n_tests = 0;
  int n_fail  = 0;
  int n_gs = 0;
  int n_ds = 0;
  int n_ms = 0;
  int t_gs = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  sift_stage_sequencer #(.TIMEOUT_CYC(100), .CNT_W(8)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .gauss_start (gauss_start),
    .detect_start(detect_start),
    .match_start (match_start),
    .gauss_done  (gauss_done),
    .detect_done (detect_done),
    .match_done  (match_done),
    .kpt1_cnt    (kpt1_cnt),
    .kpt2_cnt    (kpt2_cnt),
    .sel         (sel),
    .busy        (busy),
    .err         (err),
    .out_valid   (out_valid),
    .out_data    (out_data)
  );

  sift_stage_sequencer #(.TIMEOUT_CYC(16), .CNT_W(5)) u_dut_t (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .gauss_start (t_gauss_start),
    .detect_start(t_detect_start),
    .match_start (t_match_start),
    .gauss_done  (gauss_done),
    .detect_done (detect_done),
    .match_done  (match_done),
    .kpt1_cnt    (kpt1_cnt),
    .kpt2_cnt    (kpt2_cnt),
    .sel         (t_sel),
    .busy        (t_busy),
    .err         (t_err),
    .out_valid   (t_out_valid),
    .out_data    (t_out_data)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (gauss_start)   n_gs++;
    if (detect_start)  n_ds++;
    if (match_start)   n_ms++;
    if (t_gauss_start) t_gs++;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(out_data), 32'h1_0000);
      end else begin
        check("rpt_word", 32'(out_data), 32'(sb.pop_front()));
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic start_run();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    tick();
  endtask

  task automatic do_run(input int gg, input int gd, input logic [10:0] k1,
                        input logic [10:0] k2, input int gm);
    int gs0, ds0, ms0;
    bit zero;
    zero = (k1 == 11'd0) && (k2 == 11'd0);
    gs0 = n_gs;
    ds0 = n_ds;
    ms0 = n_ms;
    start_run();
    check("g_start", gauss_start, 1);
    check("g_sel", sel, 1);
    check("g_busy", busy, 1);
    repeat (gg) tick();
    gauss_done = 1'b1;
    tick();
    gauss_done = 1'b0;
    check("d_start", detect_start, 1);
    check("d_sel", sel, 2);
    repeat (gd) tick();
    detect_done = 1'b1;
    kpt1_cnt = k1;
    kpt2_cnt = k2;
    sb.push_back({5'b0, k1});
    sb.push_back({5'b0, k2});
    sb.push_back(16'(gd + 1));
    if (zero) sb.push_back(16'd0);
    tick();
    detect_done = 1'b0;
    kpt1_cnt = 11'h7ff;
    kpt2_cnt = 11'h003;
    if (zero) begin
      check("rpt_enter", out_valid, 1);
    end else begin
      check("m_start", match_start, 1);
      check("m_sel", sel, 3);
      repeat (gm) tick();
      match_done = 1'b1;
      sb.push_back(16'(gm + 1));
      tick();
      match_done = 1'b0;
    end
    repeat (4) tick();
    check("end_busy", busy, 0);
    check("end_sel", sel, 0);
    check("end_ov", out_valid, 0);
    check("end_od", out_data, 0);
    repeat (3) tick();
    check("no_restart", busy, 0);
    check("gs_cnt", n_gs - gs0, 1);
    check("ds_cnt", n_ds - ds0, 1);
    check("ms_cnt", n_ms - ms0, zero ? 0 : 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int gs0, ds0, tg0;
    do_reset();
    check("rst_sel", sel, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_ov", out_valid, 0);
    check("rst_od", out_data, 0);
    check("rst_gs", gauss_start, 0);

    do_run(10, 20, 11'd5, 11'd7, 30);
    do_run(3, 4, 11'd2047, 11'd1, 5);
    do_run(2, 6, 11'd0, 11'd0, 0);

    // spurious dones / in_valid pulses while in GAUSS
    gs0 = n_gs;
    ds0 = n_ds;
    start_run();
    gauss_done = 1'b1;
    tick();
    gauss_done = 1'b0;
    match_done = 1'b1;
    detect_done = 1'b1;
    tick();
    match_done = 1'b0;
    detect_done = 1'b0;
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    tick();
    check("spur_sel", sel, 1);
    check("spur_gs", n_gs - gs0, 1);
    check("spur_ds", n_ds - ds0, 0);
    gauss_done = 1'b1;
    tick();
    gauss_done = 1'b0;
    repeat (2) tick();
    detect_done = 1'b1;
    kpt1_cnt = 11'd0;
    kpt2_cnt = 11'd0;
    sb.push_back(16'd0);
    sb.push_back(16'd0);
    sb.push_back(16'd3);
    sb.push_back(16'd0);
    tick();
    detect_done = 1'b0;
    repeat (5) tick();
    check("spur_end", busy, 0);

    // timeout on the 16-cycle instance
    do_reset();
    tg0 = t_gs;
    start_run();
    repeat (15) tick();
    check("tmo_err_pre", t_err, 0);
    check("tmo_sel_pre", t_sel, 1);
    tick();
    check("tmo_err", t_err, 1);
    check("tmo_sel", t_sel, 0);
    gauss_done = 1'b1;
    in_valid = 1'b0;
    tick();
    gauss_done = 1'b0;
    in_valid = 1'b1;
    repeat (3) tick();
    check("tmo_sticky", t_err, 1);
    check("tmo_sel_post", t_sel, 0);
    check("tmo_gs", t_gs - tg0, 1);
    do_reset();
    check("tmo_rst_err", t_err, 0);

    // done coincident with timeout count
    start_run();
    repeat (15) tick();
    gauss_done = 1'b1;
    tick();
    gauss_done = 1'b0;
    check("coin_sel", t_sel, 2);
    check("coin_err", t_err, 0);
    check("coin_ds", t_detect_start, 1);
    do_reset();

    // reset during DETECT, with in_valid held high
    gs0 = n_gs;
    start_run();
    repeat (3) tick();
    gauss_done = 1'b1;
    tick();
    gauss_done = 1'b0;
    repeat (2) tick();
    check("mid_sel", sel, 2);
    rst_n = 1'b0;
    tick();
    check("mid_rst_sel", sel, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ds", detect_start, 0);
    check("mid_rst_ov", out_valid, 0);
    rst_n = 1'b1;
    repeat (5) tick();
    check("mid_hold_busy", busy, 0);
    check("mid_hold_gs", n_gs - gs0, 1);
    start_run();
    check("mid_restart", gauss_start, 1);
    do_reset();

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
